// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, decryption FSM states and the GF(2^8) helpers
// used by the inverse-round datapath.
package aes_pkg;

  localparam int unsigned AES_NR    = 14;
  localparam int unsigned AES_BLK_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ROUND,
    FINAL,
    DONE
  } aes_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Inverse affine transform followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // One column, row 0 in the most significant byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

endpackage

// File: rtl/aes_inv_round_dp.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// unless last is set, InvMixColumns.
module aes_inv_round_dp
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] st_in,
  input  logic [AES_BLK_W-1:0] rk,
  input  logic                 last,
  output logic [AES_BLK_W-1:0] st_out
);

  logic [AES_BLK_W-1:0] shifted;
  logic [AES_BLK_W-1:0] subbed;
  logic [AES_BLK_W-1:0] keyed;
  logic [AES_BLK_W-1:0] mixed;

  // Byte i sits at row i%4, column i/4; row r rotates right by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shifted[AES_BLK_W-1-8*(4*c+r) -: 8] =
        st_in[AES_BLK_W-1-8*(4*((c+4-r)%4)+r) -: 8];
      assign subbed[AES_BLK_W-1-8*(4*c+r) -: 8] =
        inv_sbox(shifted[AES_BLK_W-1-8*(4*c+r) -: 8]);
    end
    assign mixed[AES_BLK_W-1-32*c -: 32] = inv_mix_col(keyed[AES_BLK_W-1-32*c -: 32]);
  end

  assign keyed  = subbed ^ rk;
  assign st_out = last ? keyed : mixed;

endmodule

// File: rtl/aes256_dec_round_sched.sv
// Iterative AES-256 decryption controller: owns the state register, round counter
// and round-key fetch handshake around one shared inverse-round datapath.
module aes256_dec_round_sched
  import aes_pkg::*;
#(
  parameter int unsigned NR    = AES_NR,
  parameter int unsigned IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_block,
  output logic                 rk_req,
  output logic [IDX_W-1:0]     rk_idx,
  input  logic                 rk_valid,
  input  logic [AES_BLK_W-1:0] rk,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_block,
  output logic                 busy
);

  aes_state_e           state_q, state_d;
  logic [AES_BLK_W-1:0] st_q, st_d, dp_out;
  logic [IDX_W-1:0]     cnt_q, cnt_d, rk_idx_d;
  logic                 in_ready_d, rk_req_d, out_valid_d, busy_d;
  logic                 dp_last;

  assign dp_last = (state_q == FINAL);

  aes_inv_round_dp u_dp (
    .st_in  (st_q),
    .rk     (rk),
    .last   (dp_last),
    .st_out (dp_out)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      st_q      <= '0;
      cnt_q     <= '0;
      in_ready  <= 1'b0;
      rk_req    <= 1'b0;
      rk_idx    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      in_ready  <= in_ready_d;
      rk_req    <= rk_req_d;
      rk_idx    <= rk_idx_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
    end
  end

  // Next state; without rk_valid every waiting state holds st and cnt.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          st_d    = in_block;
          cnt_d   = IDX_W'(NR);
          state_d = INIT;
        end
      end
      INIT: begin
        if (rk_valid) begin
          st_d    = st_q ^ rk;
          cnt_d   = IDX_W'(NR - 1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (rk_valid) begin
          st_d  = dp_out;
          cnt_d = cnt_q - IDX_W'(1);
          if (cnt_q == IDX_W'(1)) state_d = FINAL;
        end
      end
      FINAL: begin
        if (rk_valid) begin
          st_d    = dp_out;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so they register alongside it.
  always_comb begin
    in_ready_d  = 1'b0;
    rk_req_d    = 1'b0;
    rk_idx_d    = '0;
    out_valid_d = 1'b0;
    busy_d      = 1'b1;
    unique case (state_d)
      IDLE: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
      INIT: begin
        rk_req_d = 1'b1;
        rk_idx_d = IDX_W'(NR);
      end
      ROUND: begin
        rk_req_d = 1'b1;
        rk_idx_d = cnt_d;
      end
      FINAL: begin
        rk_req_d = 1'b1;
      end
      DONE: begin
        out_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign out_block = st_q;

endmodule

// File: tb/tb_aes256_dec_round_sched.sv
// Directed bench for aes256_dec_round_sched: an independent forward-cipher model
// produces ciphertexts, and a key-store responder serves round keys with optional stalls.
module tb_aes256_dec_round_sched;

  localparam int unsigned IDX_W = 4;
  localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] C3_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_block;
  logic             rk_req;
  logic [IDX_W-1:0] rk_idx;
  logic             rk_valid;
  logic [127:0]     rk;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_block;
  logic             busy;

  aes256_dec_round_sched #(.NR(14), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .rk_req    (rk_req),
    .rk_idx    (rk_idx),
    .rk_valid  (rk_valid),
    .rk        (rk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [127:0] rk_tab [16];
  logic [IDX_W-1:0] key_log [$];

  always @(posedge clk) cyc <= cyc + 1;

  assign rk = rk_tab[rk_idx];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (forward cipher) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    while (y != 8'h00) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    for (int y = 1; y < 256; y++)
      if (gmul(a, 8'(y)) == 8'h01) return 8'(y);
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = ginv(x);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  task automatic expand_key(input logic [255:0] key);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rcon;
    logic [255:0] k;
    k = key;
    rcon = 8'h01;
    for (int i = 0; i < 8; i++) begin
      w[i] = k[255:224];
      k = k << 32;
    end
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    rk_tab[15] = '0;
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] b;
    b = pt ^ rk_tab[0];
    for (int r = 1; r <= 14; r++) begin
      for (int i = 0; i < 16; i++) begin
        s[i] = sbox(b[127:120]);
        b = b << 8;
      end
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[4*c+w] = s[4*((c+w)%4)+w];
      for (int c = 0; c < 4; c++) begin
        if (r == 14) begin
          for (int w = 0; w < 4; w++) s[4*c+w] = t[4*c+w];
        end else begin
          s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) b = {b[119:0], s[i]};
      b = b ^ rk_tab[r];
    end
    return b;
  endfunction

  // ---------------- key-store responder ----------------
  bit               stall_mode = 1'b0;
  int               wait_left = -1;
  bit               prev_req = 1'b0;
  bit               prev_valid = 1'b0;
  logic [IDX_W-1:0] prev_idx = '0;

  always @(negedge clk) begin
    if (stall_mode && rk_req && prev_req && !prev_valid) begin
      checks++;
      if (rk_idx !== prev_idx) begin
        errors++;
        $display("FAIL stall_idx_stable: got %0d expected %0d", rk_idx, prev_idx);
      end
    end
    if (!stall_mode) begin
      rk_valid = 1'b1;
    end else if (!rk_req) begin
      rk_valid = 1'b0;
      wait_left = -1;
    end else begin
      if (wait_left < 0) wait_left = int'($urandom_range(0, 5));
      if (wait_left == 0) begin
        rk_valid = 1'b1;
        wait_left = -1;
      end else begin
        rk_valid = 1'b0;
        wait_left--;
      end
    end
    if (rk_req && rk_valid) key_log.push_back(rk_idx);
    prev_req   = rk_req;
    prev_valid = rk_valid;
    prev_idx   = rk_idx;
  end

  // ---------------- stimulus helpers ----------------
  task automatic accept(input logic [127:0] ct);
    int n;
    n = 0;
    key_log.delete();
    @(negedge clk);
    in_valid = 1'b1;
    in_block = ct;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
    end
    acc_cyc = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input logic [127:0] exp, input string name, input bit chk_lat,
                          input int hold);
    int n;
    n = 0;
    if (hold > 0) out_ready = 1'b0;
    while (!out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_out_valid"}, 128'(out_valid), 128'(1));
    chk({name, "_out_block"}, out_block, exp);
    if (chk_lat) chk({name, "_latency"}, 128'(cyc - acc_cyc), 128'(15));
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        in_valid = ((h % 2) == 0);
        in_block = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        chk({name, "_hold_valid"}, 128'(out_valid), 128'(1));
        chk({name, "_hold_block"}, out_block, exp);
        chk({name, "_hold_in_ready"}, 128'(in_ready), 128'(0));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk({name, "_idle_in_ready"}, 128'(in_ready), 128'(1));
      chk({name, "_idle_out_valid"}, 128'(out_valid), 128'(0));
      chk({name, "_idle_busy"}, 128'(busy), 128'(0));
    end
  endtask

  task automatic check_keys(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < key_log.size(); i++)
      if (bad < 0 && int'(key_log[i]) != 14 - i) bad = i;
    checks++;
    if (key_log.size() != 15 || bad >= 0) begin
      errors++;
      $display("FAIL %s_key_order: got %0d handshakes (first bad position %0d) expected 15 in order 14..0",
               name, key_log.size(), bad);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_in_ready"}, 128'(in_ready), 128'(0));
    chk({name, "_busy"}, 128'(busy), 128'(0));
    chk({name, "_rk_req"}, 128'(rk_req), 128'(0));
    chk({name, "_rk_idx"}, 128'(rk_idx), 128'(0));
    chk({name, "_out_valid"}, 128'(out_valid), 128'(0));
    chk({name, "_out_block"}, out_block, 128'(0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n;
    int last_acc;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_block = '0;
    out_ready = 1'b1;
    expand_key(C3_KEY);
    vecs[0].ct = C3_CT;
    vecs[0].pt = C3_PT;
    for (int i = 1; i < 5; i++) begin
      vecs[i].pt = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].ct = encrypt(vecs[i].pt);
    end
    chk("model_c3_encrypt", encrypt(C3_PT), C3_CT);

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", 128'(in_ready), 128'(1));
    chk("post_reset_busy", 128'(busy), 128'(0));

    // C.3 followed by four back-to-back random blocks, rk_valid tied high.
    last_acc = 0;
    for (int v = 0; v < 5; v++) begin
      accept(vecs[v].ct);
      chk($sformatf("vec%0d_busy", v), 128'(busy), 128'(1));
      if (v > 0) chk($sformatf("vec%0d_accept_gap", v), 128'(acc_cyc - last_acc), 128'(17));
      last_acc = acc_cyc;
      wait_out(vecs[v].pt, $sformatf("vec%0d", v), 1'b1, 0);
      check_keys($sformatf("vec%0d", v));
    end

    // Random round-key stalls.
    @(negedge clk);
    stall_mode = 1'b1;
    accept(C3_CT);
    wait_out(C3_PT, "stall", 1'b0, 0);
    check_keys("stall");
    @(negedge clk);
    stall_mode = 1'b0;

    // Downstream back-pressure for ten cycles.
    accept(C3_CT);
    wait_out(C3_PT, "hold", 1'b1, 10);

    // Reset in the middle of ROUND at cnt=7, then a fresh block.
    accept(vecs[1].ct);
    n = 0;
    while (!(rk_req && rk_idx == IDX_W'(7)) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("midreset_reached_idx7", 128'(rk_idx), 128'(7));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_release_in_ready", 128'(in_ready), 128'(1));
    chk("midreset_release_out_valid", 128'(out_valid), 128'(0));
    accept(C3_CT);
    wait_out(C3_PT, "after_reset", 1'b1, 0);
    check_keys("after_reset");

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
